// File: rtl/adder_arb_pkg.sv
// ============================================================================
// Module      : adder_arb_pkg
// Description : Shared defaults and FSM state type for the adder arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_arb_pkg;

    localparam int c_N_REQ_DEFAULT = 4;
    localparam int c_W_DEFAULT     = 4;
    localparam int c_CNT_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/adder.sv
// ============================================================================
// Module      : adder
// Description : Plain W-bit modular adder (sum wraps, no carry out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

`default_nettype wire

// File: rtl/adder_arbiter_rr_select.sv
// ============================================================================
// Module      : rr_select
// Description : Combinational round-robin picker: first valid index at or
//               above the pointer, wrapping; one-hot grant plus encoded index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_select #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_valid,
    input  logic [ID_W-1:0] rr_ptr,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en && !any && req_valid[(int'(rr_ptr) + i) % N]) begin
                grant[(int'(rr_ptr) + i) % N] = 1'b1;
                idx                           = ID_W'((int'(rr_ptr) + i) % N);
                any                           = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin arbiter sharing one W-bit adder between N_REQ
//               requesters, with a held valid/ready response and op counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = c_N_REQ_DEFAULT,
    parameter int W     = c_W_DEFAULT,
    parameter int CNT_W = c_CNT_W_DEFAULT,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W-1:0]       rsp_sum,
    output logic               rsp_carry,
    output logic [ID_W-1:0]    rsp_id,
    output logic [CNT_W-1:0]   op_count,
    output logic               busy
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic [ID_W-1:0]  r_id;
    logic [CNT_W-1:0] r_op_count;

    logic             w_can_accept;
    logic             w_accept;
    logic [ID_W-1:0]  w_idx;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic [W-1:0]     w_sum;
    logic             w_carry;
    logic [W-1:0]     w_a_arr [N_REQ];
    logic [W-1:0]     w_b_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_a_arr[gi] = req_a[gi*W +: W];
            assign w_b_arr[gi] = req_b[gi*W +: W];
        end
    endgenerate

    // Gating with rst_n keeps req_ready low for the whole reset interval.
    assign w_can_accept = rst_n && ((r_state == IDLE) || rsp_ready);

    rr_select #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_select (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .en        (w_can_accept),
        .grant     (req_ready),
        .idx       (w_idx),
        .any       (w_accept)
    );

    assign w_a = w_a_arr[w_idx];
    assign w_b = w_b_arr[w_idx];

    adder #(
        .W (W)
    ) u_adder (
        .a   (w_a),
        .b   (w_b),
        .sum (w_sum)
    );

    assign w_carry = 1'(({1'b0, w_a} + {1'b0, w_b}) >> W);

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = HOLD;
        end else if (r_state == HOLD && rsp_ready) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_id       <= '0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_sum    <= w_sum;
                r_carry  <= w_carry;
                r_id     <= w_idx;
                r_rr_ptr <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
            if (r_state == HOLD && rsp_ready) begin
                r_op_count <= r_op_count + 1'b1;
            end
        end
    end

    assign rsp_valid = (r_state == HOLD);
    assign busy      = (r_state == HOLD);
    assign rsp_sum   = r_sum;
    assign rsp_carry = r_carry;
    assign rsp_id    = r_id;
    assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Self-checking bench for adder_arbiter against a behavioural
//               model of the grant, response and counter rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int CW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_sum;
    logic            rsp_carry;
    logic [IW-1:0]   rsp_id;
    logic [CW-1:0]   op_count;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_hold;
    int m_ptr, m_sum, m_carry, m_id, m_cnt;

    adder_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .op_count  (op_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int model_grant();
        if (!rst_n || (m_hold && !rsp_ready)) return -1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = model_grant();
        return (g < 0) ? '0 : N'(1) << g;
    endfunction

    function automatic logic [20:0] exp_vec();
        return {m_hold, m_hold, 4'(m_sum), 1'(m_carry), 2'(m_id), 8'(m_cnt), exp_ready()};
    endfunction

    function automatic logic [20:0] act_vec();
        return {rsp_valid, busy, rsp_sum, rsp_carry, rsp_id, op_count, req_ready};
    endfunction

    task automatic model_reset();
        m_hold = 0; m_ptr = 0; m_sum = 0; m_carry = 0; m_id = 0; m_cnt = 0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        int g, s;
        g = model_grant();
        @(posedge clk);
        if (m_hold && rsp_ready) m_cnt = (m_cnt + 1) % 256;
        if (g >= 0) begin
            s       = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
            m_sum   = s % 16;
            m_carry = s / 16;
            m_id    = g;
            m_ptr   = (g + 1) % N;
            m_hold  = 1;
        end else if (m_hold && rsp_ready) begin
            m_hold = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_operands();
        req_a = N*W'($urandom);
        req_b = N*W'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        model_reset();
        #2;
        n_checks++;
        if (act_vec() !== 21'd0) begin
            n_errors++;
            $display("FAIL reset_state: got %h expected 0", act_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        req_valid = 4'b0100; rsp_ready = 1'b1;
        req_a = '0; req_b = '0;
        req_a[2*W +: W] = 4'd3; req_b[2*W +: W] = 4'd4;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_errors++;
            $display("FAIL single_grant: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        n_checks++;
        if ({rsp_valid, busy, rsp_sum, rsp_carry, rsp_id} !== {1'b1, 1'b1, 4'd7, 1'b0, 2'd2}) begin
            n_errors++;
            $display("FAIL single_rsp: got v=%b b=%b s=%0d c=%b id=%0d expected v=1 b=1 s=7 c=0 id=2",
                     rsp_valid, busy, rsp_sum, rsp_carry, rsp_id);
        end
        tick();
        n_checks++;
        if ({rsp_valid, op_count} !== {1'b0, 8'd1}) begin
            n_errors++;
            $display("FAIL single_count: got v=%b cnt=%0d expected v=0 cnt=1", rsp_valid, op_count);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] av [2] = '{4'd9, 4'd15};
        logic [3:0] bv [2] = '{4'd8, 4'd15};
        logic [4:0] ev [2] = '{{4'd1, 1'b1}, {4'd14, 1'b1}};
        rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid = 4'b0001;
            req_a[0 +: W] = av[k]; req_b[0 +: W] = bv[k];
            #1;
            tick();
            req_valid = '0;
            #1;
            n_checks++;
            if ({rsp_sum, rsp_carry} !== ev[k]) begin
                n_errors++;
                $display("FAIL overflow_%0d: got s=%0d c=%b expected s=%0d c=%b",
                         k, rsp_sum, rsp_carry, ev[k][4:1], ev[k][0]);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = '1; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_operands();
            #1;
            n_checks++;
            if (req_ready !== (4'b0001 << (k % 4))) begin
                n_errors++;
                $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, 4'b0001 << (k % 4));
            end
            tick();
            n_checks++;
            if (act_vec() !== exp_vec() || rsp_id !== 2'(k % 4)) begin
                n_errors++;
                $display("FAIL rr_rsp_%0d: got %h expected %h", k, act_vec(), exp_vec());
            end
        end
        do_reset();
        req_valid = 4'b1000;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_errors++;
            $display("FAIL rr_first3: got %b expected 1000", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_errors++;
            $display("FAIL rr_then1: got %b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0001; rsp_ready = 1'b0;
        rand_operands();
        #1;
        tick();
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            rand_operands();
            #1;
            n_checks++;
            if (act_vec() !== exp_vec() || req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL bp_hold_%0d: got %h expected %h", k, act_vec(), exp_vec());
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== exp_ready() || req_ready === 4'b0000) begin
            n_errors++;
            $display("FAIL bp_release_grant: got %b expected %b", req_ready, exp_ready());
        end
        tick();
        n_checks++;
        if (act_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL bp_release_rsp: got %h expected %h", act_vec(), exp_vec());
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_counter_wrap();
        bit seen_255 = 0;
        bit seen_wrap = 0;
        do_reset();
        req_valid = '1; rsp_ready = 1'b1;
        for (int i = 0; i < 300 && !seen_wrap; i++) begin
            rand_operands();
            #1;
            if (m_cnt == 255) begin
                seen_255 = 1;
                n_checks++;
                if (op_count !== 8'd255) begin
                    n_errors++;
                    $display("FAIL wrap_255: got %0d expected 255", op_count);
                end
            end else if (seen_255 && m_cnt == 0) begin
                seen_wrap = 1;
                n_checks++;
                if (op_count !== 8'd0) begin
                    n_errors++;
                    $display("FAIL wrap_0: got %0d expected 0", op_count);
                end
            end
            tick();
        end
        n_checks++;
        if (!seen_wrap) begin
            n_errors++;
            $display("FAIL wrap_reached: got seen=%b expected 1", seen_wrap);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_operands();
            #1;
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL random_%0d: got %h expected %h", i, act_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_reset_hold();
        req_valid = '1; rsp_ready = 1'b1;
        rand_operands();
        #1; tick();
        #1; tick();
        rsp_ready = 1'b0;
        #1; tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({rsp_valid, busy, op_count} !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_hold: got v=%b b=%b cnt=%0d expected all 0", rsp_valid, busy, op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_errors++;
            $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
        end
        tick();
        n_checks++;
        if (act_vec() !== exp_vec() || rsp_id !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_first_rsp: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_counter_wrap();
        test_random();
        test_reset_hold();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
